// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, constants and payload types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = 5;

    localparam logic [IDX_W-1:0] REG_ZERO = IDX_W'(0);

    // Port identifiers as stored in last_grant.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic is_reg_zero(input logic [IDX_W-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the regfile.
// Optional macro WB_FWD_EN adds the decode forwarding signals.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [IDX_W-1:0]  req0_index;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [IDX_W-1:0]  req1_index;
    logic [DATA_W-1:0] req1_data;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_index;
    logic [DATA_W-1:0] rd_data;
    logic              conflict_stall;

`ifdef WB_FWD_EN
    logic [IDX_W-1:0]  fwd_rs1_index;
    logic [IDX_W-1:0]  fwd_rs2_index;
    logic              fwd_rs1_hit;
    logic              fwd_rs2_hit;
    logic [DATA_W-1:0] fwd_rs1_data;
    logic [DATA_W-1:0] fwd_rs2_data;

    modport master (
        output req0_valid, req0_index, req0_data,
        output req1_valid, req1_index, req1_data,
        input  req0_ready, req1_ready,
        input  rd_en, rd_index, rd_data, conflict_stall,
        output fwd_rs1_index, fwd_rs2_index,
        input  fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
    );

    modport slave (
        input  req0_valid, req0_index, req0_data,
        input  req1_valid, req1_index, req1_data,
        output req0_ready, req1_ready,
        output rd_en, rd_index, rd_data, conflict_stall,
        input  fwd_rs1_index, fwd_rs2_index,
        output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
    );
`else
    modport master (
        output req0_valid, req0_index, req0_data,
        output req1_valid, req1_index, req1_data,
        input  req0_ready, req1_ready,
        input  rd_en, rd_index, rd_data, conflict_stall
    );

    modport slave (
        input  req0_valid, req0_index, req0_data,
        input  req1_valid, req1_index, req1_data,
        output req0_ready, req1_ready,
        output rd_en, rd_index, rd_data, conflict_stall
    );
`endif

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational two-way round-robin grant with a same-destination override
// that favours port 0, the older in-order producer.
module wb_rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic             valid0,
    input  logic             valid1,
    input  logic [IDX_W-1:0] index0,
    input  logic [IDX_W-1:0] index1,
    input  logic             last_grant,
    output logic             grant0_c,
    output logic             grant1_c,
    output logic             next_last_grant_c
);

    // Grant selection and last_grant update.
    always_comb begin
        grant0_c          = 1'b0;
        grant1_c          = 1'b0;
        next_last_grant_c = last_grant;

        if (valid0 && valid1) begin
            if ((index0 == index1) && !is_reg_zero(index0)) begin
                grant0_c = 1'b1;
            end else if (last_grant == PORT0) begin
                grant1_c = 1'b1;
            end else begin
                grant0_c = 1'b1;
            end
        end else if (valid0) begin
            grant0_c = 1'b1;
        end else if (valid1) begin
            grant1_c = 1'b1;
        end

        if (grant0_c) begin
            next_last_grant_c = PORT0;
        end else if (grant1_c) begin
            next_last_grant_c = PORT1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the LSU (port 0) and ALU/CSR (port 1)
// writeback paths and registers the winning write.
// Optional macro WB_FWD_EN adds rs1/rs2 forwarding from the output register.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic              last_grant;
    logic              grant0_c;
    logic              grant1_c;
    logic              next_last_grant_c;
    wb_req_t           win_c;
    logic              win_valid_c;
    logic              rd_en_q;
    logic [IDX_W-1:0]  rd_index_q;
    logic [DATA_W-1:0] rd_data_q;

    wb_rr_arbiter2 u_arb (
        .valid0            (bus.req0_valid),
        .valid1            (bus.req1_valid),
        .index0            (bus.req0_index),
        .index1            (bus.req1_index),
        .last_grant        (last_grant),
        .grant0_c          (grant0_c),
        .grant1_c          (grant1_c),
        .next_last_grant_c (next_last_grant_c)
    );

    // Nothing is acknowledged while reset is held.
    assign bus.req0_ready     = grant0_c && !rst;
    assign bus.req1_ready     = grant1_c && !rst;
    assign bus.conflict_stall = bus.req0_valid && bus.req1_valid;

    // Mux the granted request onto the write payload.
    always_comb begin
        win_valid_c = grant0_c || grant1_c;
        win_c.index = bus.req1_index;
        win_c.data  = bus.req1_data;
        if (grant0_c) begin
            win_c.index = bus.req0_index;
            win_c.data  = bus.req0_data;
        end
    end

    // Round-robin pointer; reset to port 1 so port 0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT1;
        end else begin
            last_grant <= next_last_grant_c;
        end
    end

    // Output register; writes to the zero register are acknowledged but dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q    <= 1'b0;
            rd_index_q <= IDX_W'(0);
            rd_data_q  <= DATA_W'(0);
        end else begin
            rd_en_q <= win_valid_c && !is_reg_zero(win_c.index);
            if (win_valid_c && !is_reg_zero(win_c.index)) begin
                rd_index_q <= win_c.index;
                rd_data_q  <= win_c.data;
            end
        end
    end

    assign bus.rd_en    = rd_en_q;
    assign bus.rd_index = rd_index_q;
    assign bus.rd_data  = rd_data_q;

`ifdef WB_FWD_EN
    // Forward the value being written this cycle to decode.
    assign bus.fwd_rs1_hit  = rd_en_q && (rd_index_q == bus.fwd_rs1_index) &&
                              !is_reg_zero(bus.fwd_rs1_index);
    assign bus.fwd_rs2_hit  = rd_en_q && (rd_index_q == bus.fwd_rs2_index) &&
                              !is_reg_zero(bus.fwd_rs2_index);
    assign bus.fwd_rs1_data = bus.fwd_rs1_hit ? rd_data_q : DATA_W'(0);
    assign bus.fwd_rs2_data = bus.fwd_rs2_hit ? rd_data_q : DATA_W'(0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [IDX_W-1:0] i0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [IDX_W-1:0] i1, input logic [DATA_W-1:0] d1);
        bus.req0_valid = v0;
        bus.req0_index = i0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_index = i1;
        bus.req1_data  = d1;
    endtask

    task automatic idle();
        drive(1'b0, IDX_W'(0), DATA_W'(0), 1'b0, IDX_W'(0), DATA_W'(0));
    endtask

    initial begin
        rst = 1'b1;
        idle();
`ifdef WB_FWD_EN
        bus.fwd_rs1_index = IDX_W'(0);
        bus.fwd_rs2_index = IDX_W'(0);
`endif
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_rd_en",    64'(bus.rd_en), 64'd0);
        chk("rst_rd_index", 64'(bus.rd_index), 64'd0);
        chk("rst_rd_data",  64'(bus.rd_data), 64'd0);
        chk("rst_ready0",   64'(bus.req0_ready), 64'd0);
        chk("rst_ready1",   64'(bus.req1_ready), 64'd0);
        chk("rst_stall",    64'(bus.conflict_stall), 64'd0);
        rst = 1'b0;

        // Lone request on port 1
        drive(1'b0, IDX_W'(0), DATA_W'(0), 1'b1, IDX_W'(5), DATA_W'('hDEAD));
        #1;
        chk("lone_ready1", 64'(bus.req1_ready), 64'd1);
        chk("lone_ready0", 64'(bus.req0_ready), 64'd0);
        chk("lone_stall",  64'(bus.conflict_stall), 64'd0);
        @(negedge clk);
        chk("lone_rd_en",    64'(bus.rd_en), 64'd1);
        chk("lone_rd_index", 64'(bus.rd_index), 64'd5);
        chk("lone_rd_data",  64'(bus.rd_data), 64'hDEAD);
        idle();
        @(negedge clk);
        chk("lone_rd_en_drop",   64'(bus.rd_en), 64'd0);
        chk("lone_rd_index_hold", 64'(bus.rd_index), 64'd5);

        // Asynchronous reset with a registered write pending
        drive(1'b1, IDX_W'(2), DATA_W'('hAB), 1'b0, IDX_W'(0), DATA_W'(0));
        @(negedge clk);
        chk("pre_rst_rd_en",    64'(bus.rd_en), 64'd1);
        chk("pre_rst_rd_index", 64'(bus.rd_index), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rd_en",    64'(bus.rd_en), 64'd0);
        chk("async_rst_rd_index", 64'(bus.rd_index), 64'd0);
        chk("async_rst_rd_data",  64'(bus.rd_data), 64'd0);
        chk("async_rst_ready0",   64'(bus.req0_ready), 64'd0);
        @(negedge clk);
        chk("in_rst_rd_en", 64'(bus.rd_en), 64'd0);
        idle();
        rst = 1'b0;

        // Contention, different indices: grants alternate 0,1,0,1
        drive(1'b1, IDX_W'(3), DATA_W'('h30), 1'b1, IDX_W'(4), DATA_W'('h40));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_ready0_%0d", k), 64'(bus.req0_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr_ready1_%0d", k), 64'(bus.req1_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
            chk($sformatf("rr_stall_%0d", k),  64'(bus.conflict_stall), 64'd1);
            @(negedge clk);
            chk($sformatf("rr_rd_en_%0d", k),    64'(bus.rd_en), 64'd1);
            chk($sformatf("rr_rd_index_%0d", k), 64'(bus.rd_index), (k % 2 == 0) ? 64'd3 : 64'd4);
            chk($sformatf("rr_rd_data_%0d", k),  64'(bus.rd_data), (k % 2 == 0) ? 64'h30 : 64'h40);
        end
        idle();

        // Lone port 0 write leaves last_grant at port 0
        drive(1'b1, IDX_W'(1), DATA_W'('h55), 1'b0, IDX_W'(0), DATA_W'(0));
        #1;
        chk("p0_ready0", 64'(bus.req0_ready), 64'd1);
        @(negedge clk);
        chk("p0_rd_index", 64'(bus.rd_index), 64'd1);

        // Same-index conflict on x7: override beats round-robin, port 1 waits
        drive(1'b1, IDX_W'(7), DATA_W'('h11), 1'b1, IDX_W'(7), DATA_W'('h22));
        #1;
        chk("same_ready0_c1", 64'(bus.req0_ready), 64'd1);
        chk("same_ready1_c1", 64'(bus.req1_ready), 64'd0);
        chk("same_stall_c1",  64'(bus.conflict_stall), 64'd1);
        @(negedge clk);
        chk("same_rd_index_c1", 64'(bus.rd_index), 64'd7);
        chk("same_rd_data_c1",  64'(bus.rd_data), 64'h11);
        drive(1'b1, IDX_W'(7), DATA_W'('h12), 1'b1, IDX_W'(7), DATA_W'('h22));
        #1;
        chk("same_ready0_c2", 64'(bus.req0_ready), 64'd1);
        chk("same_ready1_c2", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        chk("same_rd_data_c2", 64'(bus.rd_data), 64'h12);
        drive(1'b0, IDX_W'(0), DATA_W'(0), 1'b1, IDX_W'(7), DATA_W'('h22));
        #1;
        chk("same_ready1_c3", 64'(bus.req1_ready), 64'd1);
        chk("same_stall_c3",  64'(bus.conflict_stall), 64'd0);
        @(negedge clk);
        chk("same_rd_en_c3",    64'(bus.rd_en), 64'd1);
        chk("same_rd_index_c3", 64'(bus.rd_index), 64'd7);
        chk("same_rd_data_c3",  64'(bus.rd_data), 64'h22);

        // Write to x0 is acknowledged but never reaches the regfile
        drive(1'b1, IDX_W'(0), DATA_W'('hFFFF), 1'b0, IDX_W'(0), DATA_W'(0));
        #1;
        chk("x0_ready0", 64'(bus.req0_ready), 64'd1);
        @(negedge clk);
        chk("x0_rd_en", 64'(bus.rd_en), 64'd0);
        idle();

`ifdef WB_FWD_EN
        // Forwarding from the output register
        drive(1'b1, IDX_W'(9), DATA_W'('h1234), 1'b0, IDX_W'(0), DATA_W'(0));
        @(negedge clk);
        idle();
        bus.fwd_rs1_index = IDX_W'(9);
        bus.fwd_rs2_index = IDX_W'(0);
        #1;
        chk("fwd_rs1_hit",  64'(bus.fwd_rs1_hit), 64'd1);
        chk("fwd_rs1_data", 64'(bus.fwd_rs1_data), 64'h1234);
        chk("fwd_rs2_hit",  64'(bus.fwd_rs2_hit), 64'd0);
        chk("fwd_rs2_data", 64'(bus.fwd_rs2_data), 64'd0);
        @(negedge clk);
        chk("fwd_rs1_hit_after", 64'(bus.fwd_rs1_hit), 64'd0);
        chk("fwd_rs1_data_after", 64'(bus.fwd_rs1_data), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
